// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch / decode IR[31:27] / execute, one control step per Clock.
// Latency: Moore outputs valid the cycle the state is entered; R/imm/ldi 6, ld/st 8, br 7, nop 4 cycles.
// Backpressure: Read/Write states stall on mem_ack; ACK_TIMEOUT cycles without ack parks in HALTED.
module control_sequencer #(
  parameter int OPW         = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  input  logic           CON,
  input  logic           mem_ack,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           PCout,
  output logic           Zlowout,
  output logic           Zhighout,
  output logic           MDRout,
  output logic           Cout,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           Zin,
  output logic           CONin,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic [OPW-1:0] opcode,
  output logic           Run,
  output logic           mem_err,
  output logic           illegal
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_ack_cnt;
  logic          r_mem_err;

  logic [OPW-1:0] w_op;
  logic           w_unused_ir;
  logic           w_is_rtype;
  logic           w_is_imm;
  logic           w_is_ldi;
  logic           w_is_ld;
  logic           w_is_st;
  logic           w_is_br;
  logic           w_is_nop;
  logic           w_is_halt;
  logic           w_legal;
  logic           w_mem_state;
  logic           w_ack_timeout;

  // Register fields below the opcode feed the datapath's select-and-encode logic, not us.
  assign w_op        = IR[31 -: OPW];
  assign w_unused_ir = ^IR[31-OPW:0];

  assign w_is_rtype = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
  assign w_is_imm   = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
  assign w_is_ldi   = (w_op == OP_LDI);
  assign w_is_ld    = (w_op == OP_LD);
  assign w_is_st    = (w_op == OP_ST);
  assign w_is_br    = (w_op == OP_BR);
  assign w_is_nop   = (w_op == OP_NOP);
  assign w_is_halt  = (w_op == OP_HALT);
  assign w_legal    = w_is_rtype | w_is_imm | w_is_ldi | w_is_ld | w_is_st |
                      w_is_br | w_is_nop | w_is_halt;

  // States that strobe Read or Write and therefore wait for mem_ack.
  assign w_mem_state = (r_state == S_T1) ||
                       ((r_state == S_T6) && w_is_ld) ||
                       ((r_state == S_T7) && w_is_st);

  // The counter holds the number of cycles already spent waiting, so the fault fires in the
  // ACK_TIMEOUT-th cycle of a wait that still has no ack.
  assign w_ack_timeout = w_mem_state && !mem_ack && (r_ack_cnt == CW'(ACK_TIMEOUT - 1));

  assign mem_err = r_mem_err;

  // State register; clear forces RESET at once, even in the middle of a memory wait.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Ack wait counter: restarts on every state change, advances only while a memory state stalls.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_ack_cnt <= '0;
    end else if (w_next != r_state) begin
      r_ack_cnt <= '0;
    end else if (w_mem_state) begin
      r_ack_cnt <= r_ack_cnt + CW'(1);
    end
  end

  // Sticky memory-timeout flag, cleared only by clear.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_mem_err <= 1'b0;
    end else if (w_ack_timeout) begin
      r_mem_err <= 1'b1;
    end
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1: begin
        if (mem_ack)            w_next = S_T2;
        else if (w_ack_timeout) w_next = S_HALTED;
      end
      S_T2: w_next = S_T3;
      S_T3: begin
        if (w_is_halt)
          w_next = S_HALTED;
        else if (w_is_rtype || w_is_imm || w_is_ldi || w_is_ld || w_is_st || w_is_br)
          w_next = S_T4;
        else
          w_next = S_T0;  // nop and undefined opcodes
      end
      S_T4: w_next = S_T5;
      S_T5: begin
        if (w_is_ld || w_is_st || w_is_br) w_next = S_T6;
        else                               w_next = S_T0;
      end
      S_T6: begin
        if (w_is_ld) begin
          if (mem_ack)            w_next = S_T7;
          else if (w_ack_timeout) w_next = S_HALTED;
        end else if (w_is_st) begin
          w_next = S_T7;
        end else begin
          w_next = S_T0;
        end
      end
      S_T7: begin
        if (w_is_st) begin
          if (mem_ack)            w_next = S_T0;
          else if (w_ack_timeout) w_next = S_HALTED;
        end else begin
          w_next = S_T0;
        end
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_RESET;
    endcase
  end

  // Control-step decode. opcode is only driven in cycles where the ALU result is captured
  // (Zin high); address and PC arithmetic force add.
  always_comb begin
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    BAout    = 1'b0;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    CONin    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    opcode   = '0;
    illegal  = 1'b0;
    Run      = (r_state != S_RESET) && (r_state != S_HALTED);
    case (r_state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        opcode = OP_ADD;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_ack;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        illegal = !w_legal;
        if (w_is_rtype || w_is_imm) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (w_is_ldi || w_is_ld || w_is_st) begin
          Grb   = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (w_is_br) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          CONin = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_rtype) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          opcode = w_op;
        end else if (w_is_imm) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          opcode = w_op;
        end else if (w_is_ldi || w_is_ld || w_is_st) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          opcode = OP_ADD;
        end else if (w_is_br) begin
          PCout = 1'b1;
          Yin   = 1'b1;
        end
      end
      S_T5: begin
        if (w_is_rtype || w_is_imm || w_is_ldi) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end else if (w_is_ld || w_is_st) begin
          Zlowout = 1'b1;
          MARin   = 1'b1;
        end else if (w_is_br) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          opcode = OP_ADD;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          Read  = 1'b1;
          MDRin = mem_ack;
        end else if (w_is_st) begin
          Gra   = 1'b1;
          Rout  = 1'b1;
          MDRin = 1'b1;
        end else if (w_is_br) begin
          // Branch target is committed only when the condition holds this cycle.
          Zlowout = CON;
          PCin    = CON;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end else if (w_is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized instruction stream against a cycle-list reference model of the control steps.
// Each instruction is expanded into its expected control words, including memory wait cycles.
// mem_ack is driven from the model: held low for the chosen wait, random outside memory steps.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        CON;
  logic        mem_ack;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zlowout, Zhighout, MDRout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC, Read, Write;
  logic [4:0] opcode;
  logic Run, mem_err, illegal;

  always #5 Clock = ~Clock;

  control_sequencer #(.OPW(5), .ACK_TIMEOUT(15)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON(CON), .mem_ack(mem_ack),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write), .opcode(opcode),
    .Run(Run), .mem_err(mem_err), .illegal(illegal)
  );

  // Control word bit masks
  localparam logic [28:0] M_GRA   = 29'd1 << 0;
  localparam logic [28:0] M_GRB   = 29'd1 << 1;
  localparam logic [28:0] M_GRC   = 29'd1 << 2;
  localparam logic [28:0] M_RIN   = 29'd1 << 3;
  localparam logic [28:0] M_ROUT  = 29'd1 << 4;
  localparam logic [28:0] M_BAOUT = 29'd1 << 5;
  localparam logic [28:0] M_PCOUT = 29'd1 << 6;
  localparam logic [28:0] M_ZLOW  = 29'd1 << 7;
  localparam logic [28:0] M_MDROUT= 29'd1 << 9;
  localparam logic [28:0] M_COUT  = 29'd1 << 10;
  localparam logic [28:0] M_PCIN  = 29'd1 << 11;
  localparam logic [28:0] M_IRIN  = 29'd1 << 12;
  localparam logic [28:0] M_MARIN = 29'd1 << 13;
  localparam logic [28:0] M_MDRIN = 29'd1 << 14;
  localparam logic [28:0] M_YIN   = 29'd1 << 15;
  localparam logic [28:0] M_ZIN   = 29'd1 << 16;
  localparam logic [28:0] M_CONIN = 29'd1 << 17;
  localparam logic [28:0] M_INCPC = 29'd1 << 18;
  localparam logic [28:0] M_READ  = 29'd1 << 19;
  localparam logic [28:0] M_WRITE = 29'd1 << 20;
  localparam logic [28:0] M_RUN   = 29'd1 << 21;
  localparam logic [28:0] M_ILL   = 29'd1 << 22;
  localparam logic [28:0] M_MERR  = 29'd1 << 23;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110;
  localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110;
  localparam logic [4:0] BR = 5'b10010, NOP = 5'b11010, HALT = 5'b11011;

  typedef struct {
    logic [28:0] w;
    logic        ack;
    logic [31:0] ir;
    logic        con;
    string       tag;
  } step_t;

  step_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic  merr_m  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [28:0] dut_word();
    return {opcode, mem_err, illegal, Run, Write, Read, IncPC, CONin, Zin, Yin, MDRin, MARin,
            IRin, PCin, Cout, MDRout, Zhighout, Zlowout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};
  endfunction

  function automatic logic [28:0] opw(input logic [4:0] o);
    return {o, 24'd0};
  endfunction

  function automatic logic rnd_bit();
    return ($urandom_range(0, 1) != 0);
  endfunction

  task automatic push(input logic [28:0] w, input logic ack, input logic [31:0] ir,
                      input logic con, input string tag);
    step_t s;
    s.w = w; s.ack = ack; s.ir = ir; s.con = con; s.tag = tag;
    q.push_back(s);
  endtask

  // A memory step lasting `waits` ack-less cycles; 15 or more means the ack never arrives.
  task automatic mem_step(input logic [28:0] base, input logic is_read, input int waits,
                          input logic [31:0] ir, input logic con, input string tag,
                          output logic tout);
    int n;
    n = (waits < 15) ? waits : 15;
    for (int k = 0; k < n; k++) push(base | M_RUN, 1'b0, ir, con, {tag, "_wait"});
    if (waits >= 15) begin
      tout   = 1'b1;
      merr_m = 1'b1;
    end else begin
      tout = 1'b0;
      push(base | M_RUN | (is_read ? M_MDRIN : 29'd0), 1'b1, ir, con, {tag, "_ack"});
    end
  endtask

  task automatic push_halted(input int n, input logic [31:0] ir);
    for (int k = 0; k < n; k++) push(merr_m ? M_MERR : 29'd0, rnd_bit(), ir, 1'b0, "halted");
  endtask

  task automatic model_instr(input logic [31:0] ir, input logic con, input int wf,
                             input int wm, output logic halted);
    logic [4:0] op;
    logic       to;
    op     = ir[31:27];
    halted = 1'b0;
    push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | opw(ADD), rnd_bit(), ir, con, "T0");
    mem_step(M_ZLOW | M_PCIN | M_READ, 1'b1, wf, ir, con, "T1", to);
    if (to) begin halted = 1'b1; return; end
    push(M_RUN | M_MDROUT | M_IRIN, rnd_bit(), ir, con, "T2");
    case (op)
      ADD, SUB, AND_, OR_: begin
        push(M_RUN | M_GRB | M_ROUT | M_YIN, rnd_bit(), ir, con, "R_T3");
        push(M_RUN | M_GRC | M_ROUT | M_ZIN | opw(op), rnd_bit(), ir, con, "R_T4");
        push(M_RUN | M_ZLOW | M_GRA | M_RIN, rnd_bit(), ir, con, "R_T5");
      end
      ADDI, ANDI, ORI: begin
        push(M_RUN | M_GRB | M_ROUT | M_YIN, rnd_bit(), ir, con, "I_T3");
        push(M_RUN | M_COUT | M_ZIN | opw(op), rnd_bit(), ir, con, "I_T4");
        push(M_RUN | M_ZLOW | M_GRA | M_RIN, rnd_bit(), ir, con, "I_T5");
      end
      LDI, LD, ST: begin
        push(M_RUN | M_GRB | M_BAOUT | M_YIN, rnd_bit(), ir, con, "A_T3");
        push(M_RUN | M_COUT | M_ZIN | opw(ADD), rnd_bit(), ir, con, "A_T4");
        if (op == LDI) begin
          push(M_RUN | M_ZLOW | M_GRA | M_RIN, rnd_bit(), ir, con, "LDI_T5");
        end else begin
          push(M_RUN | M_ZLOW | M_MARIN, rnd_bit(), ir, con, "A_T5");
          if (op == LD) begin
            mem_step(M_READ, 1'b1, wm, ir, con, "LD_T6", to);
            if (to) begin halted = 1'b1; return; end
            push(M_RUN | M_MDROUT | M_GRA | M_RIN, rnd_bit(), ir, con, "LD_T7");
          end else begin
            push(M_RUN | M_GRA | M_ROUT | M_MDRIN, rnd_bit(), ir, con, "ST_T6");
            mem_step(M_WRITE, 1'b0, wm, ir, con, "ST_T7", to);
            if (to) begin halted = 1'b1; return; end
          end
        end
      end
      BR: begin
        push(M_RUN | M_GRA | M_ROUT | M_CONIN, rnd_bit(), ir, con, "BR_T3");
        push(M_RUN | M_PCOUT | M_YIN, rnd_bit(), ir, con, "BR_T4");
        push(M_RUN | M_COUT | M_ZIN | opw(ADD), rnd_bit(), ir, con, "BR_T5");
        push(M_RUN | (con ? (M_ZLOW | M_PCIN) : 29'd0), rnd_bit(), ir, con, "BR_T6");
      end
      NOP:  push(M_RUN, rnd_bit(), ir, con, "NOP_T3");
      HALT: begin
        push(M_RUN, rnd_bit(), ir, con, "HALT_T3");
        halted = 1'b1;
      end
      default: push(M_RUN | M_ILL, rnd_bit(), ir, con, "ILL_T3");
    endcase
  endtask

  task automatic run_q();
    step_t s;
    int    drv;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge Clock);
      mem_ack = s.ack;
      IR      = s.ir;
      CON     = s.con;
      #1;
      check_eq(s.tag, {3'd0, dut_word()}, {3'd0, s.w});
      drv = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + int'(Cout) +
            int'(Rout) + int'(BAout);
      check_eq("bus_excl", {31'd0, (drv <= 1) && !(Read && Write)}, 32'd1);
    end
  endtask

  task automatic do_clear(input string tag);
    @(negedge Clock);
    clear   = 1'b0;
    mem_ack = 1'b0;
    #1;
    check_eq({tag, "_async"}, {3'd0, dut_word()}, 32'd0);
    merr_m = 1'b0;
    repeat (2) @(negedge Clock);
    clear = 1'b1;
    #1;
    check_eq({tag, "_rst"}, {3'd0, dut_word()}, 32'd0);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[26:0]};
  endfunction

  logic [4:0] ops [16] = '{ADD, SUB, AND_, OR_, ADDI, ANDI, ORI, LDI, LD, ST, BR, NOP,
                           LD, ST, 5'b11111, 5'b00111};

  initial begin
    logic h;
    int   wf;
    int   wm;
    clear   = 1'b1;
    IR      = 32'd0;
    CON     = 1'b0;
    mem_ack = 1'b0;
    #2;
    do_clear("por");

    // Directed: add r1,r2,r3; ld with 3-cycle wait; br not-taken / taken; boundary waits
    model_instr(32'h18918000, 1'b0, 0, 0, h);
    model_instr(mk_ir(LD), 1'b0, 0, 3, h);
    model_instr(mk_ir(BR), 1'b0, 0, 0, h);
    model_instr(mk_ir(BR), 1'b1, 0, 0, h);
    model_instr(mk_ir(ST), 1'b0, 1, 2, h);
    model_instr(mk_ir(NOP), 1'b0, 14, 0, h);
    model_instr(mk_ir(LD), 1'b0, 0, 14, h);
    model_instr(mk_ir(5'b11111), 1'b0, 0, 0, h);
    model_instr(mk_ir(ORI), 1'b1, 2, 0, h);
    run_q();

    // Random instruction stream
    for (int i = 0; i < 150; i++) begin
      wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 14)) : int'($urandom_range(0, 3));
      model_instr(mk_ir(ops[$urandom_range(0, 15)]), rnd_bit(), wf, wm, h);
      run_q();
    end

    // halt: Run drops and stays low
    model_instr(mk_ir(HALT), 1'b0, 0, 0, h);
    push_halted(20, 32'd0);
    run_q();
    do_clear("exit_halt");

    // clear in the middle of a stalled fetch read
    push(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN | opw(ADD), 1'b0, 32'd0, 1'b0, "T0");
    push(M_RUN | M_ZLOW | M_PCIN | M_READ, 1'b0, 32'd0, 1'b0, "T1_wait");
    push(M_RUN | M_ZLOW | M_PCIN | M_READ, 1'b0, 32'd0, 1'b0, "T1_wait");
    run_q();
    do_clear("mid_t1");

    // fetch timeout, then execute-stage read timeout
    model_instr(mk_ir(ADD), 1'b0, 15, 0, h);
    push_halted(5, 32'd0);
    run_q();
    do_clear("after_to1");
    model_instr(mk_ir(LD), 1'b0, 0, 15, h);
    push_halted(3, 32'd0);
    run_q();
    do_clear("after_to2");
    model_instr(mk_ir(ST), 1'b0, 0, 15, h);
    push_halted(3, 32'd0);
    run_q();
    do_clear("after_to3");

    // recovery
    model_instr(mk_ir(ADDI), 1'b0, 0, 0, h);
    model_instr(mk_ir(5'b10000), 1'b0, 0, 0, h);
    run_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
